dac_fmt_slew: RTL

Multi-channel DAC output stage that takes signed two's-complement samples from the processing core, saturates them to the DAC width, slew-limits each channel, and emits registered codes in the DAC's native format (offset binary or two's complement). It sits between the SPGD actuator-update logic and the DAC pins. It replaces the bare combinational format conversion with a pipelined, per-channel protected path. On disable it ramps all channels back to midscale.

---
 rtl/dac_fmt_slew.sv | 116 +++++++++++
 1 files changed

// File: rtl/dac_fmt_slew.sv
// dac_fmt_slew: per-channel saturate, slew-limit and format stage feeding the DAC pins.
// Pipeline per channel: tgt (capture/clamp) -> cur (slew) -> out/settled (format).
module dac_fmt_slew #(
   parameter int unsigned CH       = 2,
   parameter int unsigned IN_W     = 16,
   parameter int unsigned DAC_W    = 14,
   parameter int unsigned OUT_TWOS = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en_i,
   input  logic [DAC_W-1:0]     slew_max_i,
   input  logic                 in_valid_i,
   input  logic [CH*IN_W-1:0]   in_data_i,
   input  logic                 clr_sat_i,
   output logic [CH*DAC_W-1:0]  out_data_o,
   output logic [CH-1:0]        settled_o,
   output logic [CH-1:0]        sat_flag_o
);

   localparam logic signed [DAC_W-1:0] CODE_MAX = {1'b0, {(DAC_W-1){1'b1}}};
   localparam logic signed [DAC_W-1:0] CODE_MIN = {1'b1, {(DAC_W-1){1'b0}}};
   localparam logic signed [IN_W-1:0]  IN_MAX   = IN_W'(CODE_MAX);
   localparam logic signed [IN_W-1:0]  IN_MIN   = IN_W'(CODE_MIN);
   // Output code for cur = 0 in the selected DAC format.
   localparam logic [DAC_W-1:0]        MID_CODE = (OUT_TWOS != 0) ? {DAC_W{1'b0}}
                                                                  : {1'b1, {(DAC_W-1){1'b0}}};

   genvar c;
   for (c = 0; c < CH; c++) begin : g_ch
      logic signed [IN_W-1:0]  smp_c;
      logic signed [DAC_W-1:0] clamp_c;
      logic                    clip_c;
      logic signed [DAC_W:0]   diff_c;
      logic [DAC_W:0]          mag_c;
      logic signed [DAC_W-1:0] tgt_q, tgt_d;
      logic signed [DAC_W-1:0] cur_q, cur_d;
      logic [DAC_W-1:0]        out_q, out_d;
      logic                    settled_q, settled_d;
      logic                    sat_q, sat_d;

      // Clamp the incoming signed sample into the DAC's signed range.
      always_comb begin
         smp_c   = $signed(in_data_i[c*IN_W +: IN_W]);
         clamp_c = DAC_W'(smp_c);
         clip_c  = 1'b0;
         if (smp_c > IN_MAX) begin
            clamp_c = CODE_MAX;
            clip_c  = 1'b1;
         end else if (smp_c < IN_MIN) begin
            clamp_c = CODE_MIN;
            clip_c  = 1'b1;
         end
      end

      // Target capture and sticky clip flag; a new clip beats a same-cycle clear.
      always_comb begin
         tgt_d = tgt_q;
         sat_d = sat_q;
         if (!en_i) begin
            tgt_d = '0;
         end else if (in_valid_i) begin
            tgt_d = clamp_c;
         end
         if (clr_sat_i) begin
            sat_d = 1'b0;
         end
         if (en_i && in_valid_i && clip_c) begin
            sat_d = 1'b1;
         end
      end

      // Slew limiter: one extra bit keeps tgt - cur exact for any pair of codes.
      always_comb begin
         diff_c = {tgt_q[DAC_W-1], tgt_q} - {cur_q[DAC_W-1], cur_q};
         mag_c  = diff_c[DAC_W] ? $unsigned(-diff_c) : $unsigned(diff_c);
         cur_d  = cur_q;
         if ((slew_max_i == '0) || (mag_c <= {1'b0, slew_max_i})) begin
            cur_d = tgt_q;
         end else if (diff_c[DAC_W]) begin
            cur_d = $signed(cur_q - slew_max_i);
         end else begin
            cur_d = $signed(cur_q + slew_max_i);
         end
      end

      // Output format and settled status, both from the pre-edge cur/tgt.
      always_comb begin
         out_d     = (OUT_TWOS != 0) ? $unsigned(cur_q)
                                     : {~cur_q[DAC_W-1], cur_q[DAC_W-2:0]};
         settled_d = (cur_q == tgt_q);
      end

      // Channel state registers; reset parks the channel at midscale.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            tgt_q     <= '0;
            cur_q     <= '0;
            out_q     <= MID_CODE;
            settled_q <= 1'b1;
            sat_q     <= 1'b0;
         end else begin
            tgt_q     <= tgt_d;
            cur_q     <= cur_d;
            out_q     <= out_d;
            settled_q <= settled_d;
            sat_q     <= sat_d;
         end
      end

      assign out_data_o[c*DAC_W +: DAC_W] = out_q;
      assign settled_o[c]                 = settled_q;
      assign sat_flag_o[c]                = sat_q;
   end

endmodule
